branch_redirect_ctrl: RTL and testbench
=======================================

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: PC/operand width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2: flush cycles after redirect accept (0..7).
REQ-003 SHALL have clk_i  in  1: single clock; all state on rising edge.
REQ-004 SHALL have rst_ni  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have br_valid_i  in  1: execute-stage instruction valid this cycle.
REQ-006 SHALL have opcode_i  in  7 and funct3_i  in  3: execute-stage instruction fields.
REQ-007 SHALL have breq_i, brlt_i  in  1 each: compare results from branch compare unit.
REQ-008 SHALL have pc_i, imm_i, rs1_i  in  DWIDTH: instruction PC, sign-extended immediate, rs1 data.
REQ-009 SHALL have redirect_ready_i  in  1: fetch accepts redirect.
REQ-010 SHALL have redirect_valid_o  out  1 and redirect_pc_o  out  DWIDTH: redirect request and target.
REQ-011 SHALL have flush_o  out  1: kill younger in-flight instructions.
REQ-012 SHALL have stall_o  out  1: hold execute stage and upstream.
REQ-013 SHALL have misalign_o  out  1 and illegal_o  out  1: one-cycle exception pulses.

Function
REQ-014 Taken decision SHALL be combinational: BEQ(000)=breq, BNE(001)=!breq, BLT(100)/BLTU(110)=brlt, BGE(101)/BGEU(111)=!brlt; JAL, JALR always taken; other opcodes never.
REQ-015 Branch funct3 010/011 SHALL be not-taken and pulse illegal_o the next cycle.
REQ-016 Target SHALL be pc_i+imm_i for BRANCH/JAL, (rs1_i+imm_i)&~1 for JALR, modulo 2^DWIDTH (wrap, no carry-out).
REQ-017 FSM states SHALL be IDLE, REDIRECT, FLUSH.
REQ-018 IDLE: br_valid_i && taken && target[1]==0 -> capture target into register, go REDIRECT; taken && target[1]==1 -> pulse misalign_o next cycle, stay IDLE, no redirect.
REQ-019 REDIRECT: redirect_valid_o=1, redirect_pc_o held stable until redirect_ready_i; on ready go FLUSH with counter=FLUSH_CYCLES, or IDLE directly if FLUSH_CYCLES==0.
REQ-020 FLUSH: decrement counter each cycle; return to IDLE when counter reaches 1 (exactly FLUSH_CYCLES FLUSH cycles).
REQ-021 flush_o and stall_o SHALL be 1 in REDIRECT and FLUSH, 0 in IDLE.
REQ-022 Latency: taken branch accepted in cycle N -> redirect_valid_o first high in cycle N+1.
REQ-023 br_valid_i outside IDLE SHALL be ignored (no capture, no pulses).
REQ-024 redirect_valid_o SHALL NOT drop before redirect_ready_i handshake completes.
REQ-025 redirect_pc_o SHALL be 0 whenever redirect_valid_o is 0.

Reset
REQ-026 rst_ni low SHALL immediately force IDLE, counter 0, target 0, all outputs 0, including mid-REDIRECT or mid-FLUSH.

Configuration
REQ-027 Macro BRCTRL_PERF_EN: when defined, SHALL add outputs branch_cnt_o, taken_cnt_o (32 bits each; count accepted BRANCH instrs in IDLE / taken ones incl. JAL/JALR), reset to 0, wrap at 2^32; when undefined, ports and counters SHALL be absent.

Structure
REQ-028 Opcode constants (OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR) and state enum brctrl_state_e SHALL live in the shared constants package.
REQ-029 Taken/target logic SHALL be a combinational sub-module branch_decide; FSM and registers in branch_redirect_ctrl.

Verification
REQ-030 BEQ, breq=1, pc=0x100, imm=0x20, ready=1 on first valid cycle -> redirect_pc=0x120 one cycle, then flush_o 2 more cycles, then IDLE.
REQ-031 BNE, breq=1 -> no redirect, flush_o=0, stall_o=0.
REQ-032 JALR rs1=0x1001, imm=0x4 -> redirect_pc=0x1004; ready held low 5 cycles -> valid/target stable 5 cycles.
REQ-033 BLT pc=0x200 imm=0x2, brlt=1 -> misalign_o pulse, no redirect; funct3=010 -> illegal_o pulse.
REQ-034 JAL pc=0xFFFFFFFC imm=0x8 -> redirect_pc=0x00000004 (wrap).
REQ-035 rst_ni low during FLUSH -> all outputs 0 immediately, IDLE after release; with BRCTRL_PERF_EN, counters 0.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// branch_redirect_ctrl_pkg
//   Shared constants for the branch redirect controller: RV32 control-transfer
//   opcodes, branch funct3 encodings and the controller state enum.
//   Optional feature macro used by importers: BRCTRL_PERF_EN.
// ----------------------------------------------------------------------------
package branch_redirect_ctrl_pkg;

   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } brctrl_state_e;

endpackage : branch_redirect_ctrl_pkg

// File: rtl/branch_redirect_ctrl_branch_decide.sv
// ----------------------------------------------------------------------------
// branch_decide
//   Purely combinational taken/target decision for the execute-stage
//   instruction.
//   Ports:
//     opcode_i, funct3_i  : instruction fields
//     breq_i, brlt_i      : compare-unit results
//     pc_i, imm_i, rs1_i  : PC, sign-extended immediate, rs1 data
//     taken_o             : control transfer is taken
//     illegal_o           : BRANCH opcode with reserved funct3 (010/011)
//     target_o            : redirect target, wraps modulo 2^DWIDTH
// ----------------------------------------------------------------------------
module branch_decide
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic [6:0]        opcode_i,
   input  logic [2:0]        funct3_i,
   input  logic              breq_i,
   input  logic              brlt_i,
   input  logic [DWIDTH-1:0] pc_i,
   input  logic [DWIDTH-1:0] imm_i,
   input  logic [DWIDTH-1:0] rs1_i,
   output logic              taken_o,
   output logic              illegal_o,
   output logic [DWIDTH-1:0] target_o
);

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case statements can leave it unassigned (latch).
   always_comb begin
      taken_o   = 1'b0;
      illegal_o = 1'b0;
      target_o  = pc_i + imm_i;
      case (opcode_i)
         OPCODE_BRANCH: begin
            case (funct3_i)
               F3_BEQ:           taken_o = breq_i;
               F3_BNE:           taken_o = ~breq_i;
               F3_BLT, F3_BLTU:  taken_o = brlt_i;
               F3_BGE, F3_BGEU:  taken_o = ~brlt_i;
               default:          illegal_o = 1'b1;
            endcase
         end
         OPCODE_JAL: begin
            taken_o = 1'b1;
         end
         OPCODE_JALR: begin
            taken_o  = 1'b1;
            // JALR clears the LSB of the computed address.
            target_o = (rs1_i + imm_i) & ~DWIDTH'(1);
         end
         default: ;
      endcase
   end

endmodule : branch_decide

// File: rtl/branch_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// branch_redirect_ctrl
//   Resolves execute-stage branches/jumps, issues a redirect to fetch with a
//   valid/ready handshake, then holds flush/stall for FLUSH_CYCLES cycles.
//   Ports:
//     clk_i, rst_ni             : clock, async active-low reset
//     br_valid_i                : execute-stage instruction valid
//     opcode_i, funct3_i        : instruction fields
//     breq_i, brlt_i            : compare results
//     pc_i, imm_i, rs1_i        : PC, immediate, rs1 data
//     redirect_ready_i          : fetch accepts redirect
//     redirect_valid_o/pc_o     : redirect request and target (pc 0 when idle)
//     flush_o, stall_o          : high in REDIRECT and FLUSH
//     misalign_o, illegal_o     : one-cycle exception pulses
//   Optional (macro BRCTRL_PERF_EN):
//     branch_cnt_o, taken_cnt_o : 32-bit wrapping performance counters
// ----------------------------------------------------------------------------
module branch_redirect_ctrl
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int DWIDTH       = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              br_valid_i,
   input  logic [6:0]        opcode_i,
   input  logic [2:0]        funct3_i,
   input  logic              breq_i,
   input  logic              brlt_i,
   input  logic [DWIDTH-1:0] pc_i,
   input  logic [DWIDTH-1:0] imm_i,
   input  logic [DWIDTH-1:0] rs1_i,
   input  logic              redirect_ready_i,
   output logic              redirect_valid_o,
   output logic [DWIDTH-1:0] redirect_pc_o,
   output logic              flush_o,
   output logic              stall_o,
   output logic              misalign_o,
   output logic              illegal_o
`ifdef BRCTRL_PERF_EN
   ,
   output logic [31:0]       branch_cnt_o,
   output logic [31:0]       taken_cnt_o
`endif
);

   brctrl_state_e     state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [DWIDTH-1:0] target_q, target_d;
   logic              misalign_q, misalign_d;
   logic              illegal_q, illegal_d;

   logic              dec_taken;
   logic              dec_illegal;
   logic [DWIDTH-1:0] dec_target;
   logic              accept;

   branch_decide #(
      .DWIDTH (DWIDTH)
   ) u_decide (
      .opcode_i  (opcode_i),
      .funct3_i  (funct3_i),
      .breq_i    (breq_i),
      .brlt_i    (brlt_i),
      .pc_i      (pc_i),
      .imm_i     (imm_i),
      .rs1_i     (rs1_i),
      .taken_o   (dec_taken),
      .illegal_o (dec_illegal),
      .target_o  (dec_target)
   );

   // Instructions are only looked at while idle; anything else is ignored.
   assign accept = br_valid_i && (state_q == IDLE);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      target_d   = target_q;
      misalign_d = 1'b0;
      illegal_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (dec_illegal) begin
                  illegal_d = 1'b1;
               end else if (dec_taken) begin
                  // Bit 1 set means the target is not 4-byte aligned.
                  if (dec_target[1]) begin
                     misalign_d = 1'b1;
                  end else begin
                     target_d = dec_target;
                     state_d  = REDIRECT;
                  end
               end
            end
         end
         REDIRECT: begin
            if (redirect_ready_i) begin
               if (FLUSH_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = FLUSH;
                  cnt_d   = 3'(FLUSH_CYCLES);
               end
            end
         end
         FLUSH: begin
            // Counter starts at FLUSH_CYCLES; leaving at 1 gives exactly
            // FLUSH_CYCLES cycles in this state.
            if (cnt_q <= 3'd1) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its next value from the same pre-edge snapshot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         target_q   <= '0;
         misalign_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         target_q   <= target_d;
         misalign_q <= misalign_d;
         illegal_q  <= illegal_d;
      end
   end

   // Outputs decode straight from registered state, so the async reset
   // clears them without waiting for a clock edge.
   assign redirect_valid_o = (state_q == REDIRECT);
   assign redirect_pc_o    = redirect_valid_o ? target_q : '0;
   assign flush_o          = (state_q != IDLE);
   assign stall_o          = (state_q != IDLE);
   assign misalign_o       = misalign_q;
   assign illegal_o        = illegal_q;

`ifdef BRCTRL_PERF_EN
   logic [31:0] branch_cnt_q;
   logic [31:0] taken_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         branch_cnt_q <= '0;
         taken_cnt_q  <= '0;
      end else if (accept) begin
         if (opcode_i == OPCODE_BRANCH) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
         end
         if (dec_taken) begin
            taken_cnt_q <= taken_cnt_q + 32'd1;
         end
      end
   end

   assign branch_cnt_o = branch_cnt_q;
   assign taken_cnt_o  = taken_cnt_q;
`endif

endmodule : branch_redirect_ctrl

// File: tb/tb_branch_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//   Directed self-checking bench for branch_redirect_ctrl (default params).
//   Inputs change 1 ns after the rising edge; outputs are checked in the
//   quiet part of the cycle.
// ----------------------------------------------------------------------------
module tb_branch_redirect_ctrl;
   import branch_redirect_ctrl_pkg::*;

   localparam int DWIDTH = 32;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              br_valid_i;
   logic [6:0]        opcode_i;
   logic [2:0]        funct3_i;
   logic              breq_i;
   logic              brlt_i;
   logic [DWIDTH-1:0] pc_i;
   logic [DWIDTH-1:0] imm_i;
   logic [DWIDTH-1:0] rs1_i;
   logic              redirect_ready_i;
   logic              redirect_valid_o;
   logic [DWIDTH-1:0] redirect_pc_o;
   logic              flush_o;
   logic              stall_o;
   logic              misalign_o;
   logic              illegal_o;
`ifdef BRCTRL_PERF_EN
   logic [31:0]       branch_cnt_o;
   logic [31:0]       taken_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   branch_redirect_ctrl #(
      .DWIDTH       (DWIDTH),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .br_valid_i       (br_valid_i),
      .opcode_i         (opcode_i),
      .funct3_i         (funct3_i),
      .breq_i           (breq_i),
      .brlt_i           (brlt_i),
      .pc_i             (pc_i),
      .imm_i            (imm_i),
      .rs1_i            (rs1_i),
      .redirect_ready_i (redirect_ready_i),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .flush_o          (flush_o),
      .stall_o          (stall_o),
      .misalign_o       (misalign_o),
      .illegal_o        (illegal_o)
`ifdef BRCTRL_PERF_EN
      ,
      .branch_cnt_o     (branch_cnt_o),
      .taken_cnt_o      (taken_cnt_o)
`endif
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                        input logic eq, input logic lt,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1);
      br_valid_i = 1'b1;
      opcode_i   = op;
      funct3_i   = f3;
      breq_i     = eq;
      brlt_i     = lt;
      pc_i       = pc;
      imm_i      = imm;
      rs1_i      = rs1;
   endtask

   task automatic idle_inputs();
      br_valid_i = 1'b0;
      opcode_i   = 7'd0;
      funct3_i   = 3'd0;
      breq_i     = 1'b0;
      brlt_i     = 1'b0;
      pc_i       = '0;
      imm_i      = '0;
      rs1_i      = '0;
   endtask

   // Checks every output against the quiet idle state.
   task automatic check_quiet(input string tag);
      check({tag, "_valid"},    32'(redirect_valid_o), 32'd0);
      check({tag, "_pc"},       redirect_pc_o,         32'd0);
      check({tag, "_flush"},    32'(flush_o),          32'd0);
      check({tag, "_stall"},    32'(stall_o),          32'd0);
      check({tag, "_misalign"}, 32'(misalign_o),       32'd0);
      check({tag, "_illegal"},  32'(illegal_o),        32'd0);
   endtask

   initial begin
      rst_ni           = 1'b0;
      redirect_ready_i = 1'b1;
      idle_inputs();
      step();
      step();
      check_quiet("reset");
`ifdef BRCTRL_PERF_EN
      check("reset_branch_cnt", branch_cnt_o, 32'd0);
      check("reset_taken_cnt",  taken_cnt_o,  32'd0);
`endif
      rst_ni = 1'b1;
      step();
      check_quiet("post_reset");

      // BEQ taken, fetch ready immediately: one REDIRECT cycle, two FLUSH.
      drive(OPCODE_BRANCH, F3_BEQ, 1'b1, 1'b0, 32'h100, 32'h20, 32'h0);
      step();
      idle_inputs();
      check("beq_valid", 32'(redirect_valid_o), 32'd1);
      check("beq_pc",    redirect_pc_o,         32'h120);
      check("beq_flush", 32'(flush_o),          32'd1);
      check("beq_stall", 32'(stall_o),          32'd1);
      step();
      check("beq_f1_valid", 32'(redirect_valid_o), 32'd0);
      check("beq_f1_pc",    redirect_pc_o,         32'd0);
      check("beq_f1_flush", 32'(flush_o),          32'd1);
      step();
      check("beq_f2_flush", 32'(flush_o), 32'd1);
      check("beq_f2_stall", 32'(stall_o), 32'd1);
      step();
      check_quiet("beq_idle");

      // BNE with equal operands: not taken.
      drive(OPCODE_BRANCH, F3_BNE, 1'b1, 1'b0, 32'h100, 32'h20, 32'h0);
      step();
      idle_inputs();
      check_quiet("bne");

      // JALR with back-pressure: target (0x1001+4)&~1 held for 5 cycles.
      redirect_ready_i = 1'b0;
      drive(OPCODE_JALR, 3'b000, 1'b0, 1'b0, 32'h500, 32'h4, 32'h1001);
      step();
      idle_inputs();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("jalr_hold%0d_valid", i), 32'(redirect_valid_o), 32'd1);
         check($sformatf("jalr_hold%0d_pc", i),    redirect_pc_o,         32'h1004);
         // A misaligned BLT presented mid-redirect must be ignored.
         if (i == 1) drive(OPCODE_BRANCH, F3_BLT, 1'b0, 1'b1, 32'h200, 32'h2, 32'h0);
         if (i == 2) begin
            check("jalr_ignored_misalign", 32'(misalign_o), 32'd0);
            idle_inputs();
         end
         if (i < 4) step();
      end
      redirect_ready_i = 1'b1;
      step();
      check("jalr_f1_valid", 32'(redirect_valid_o), 32'd0);
      check("jalr_f1_flush", 32'(flush_o),          32'd1);
      step();
      step();
      check_quiet("jalr_idle");

      // BLT taken to 0x202: misaligned, pulse only.
      drive(OPCODE_BRANCH, F3_BLT, 1'b0, 1'b1, 32'h200, 32'h2, 32'h0);
      step();
      idle_inputs();
      check("blt_misalign", 32'(misalign_o),       32'd1);
      check("blt_valid",    32'(redirect_valid_o), 32'd0);
      check("blt_stall",    32'(stall_o),          32'd0);
      step();
      check_quiet("blt_after");

      // Reserved branch funct3 010: illegal pulse, no redirect.
      drive(OPCODE_BRANCH, 3'b010, 1'b1, 1'b1, 32'h300, 32'h10, 32'h0);
      step();
      idle_inputs();
      check("ill_illegal", 32'(illegal_o),        32'd1);
      check("ill_valid",   32'(redirect_valid_o), 32'd0);
      check("ill_flush",   32'(flush_o),          32'd0);
      step();
      check_quiet("ill_after");

      // BLTU with brlt=0: not taken.
      drive(OPCODE_BRANCH, F3_BLTU, 1'b0, 1'b0, 32'h400, 32'h40, 32'h0);
      step();
      idle_inputs();
      check_quiet("bltu");

      // JAL target wraps past 2^32.
      drive(OPCODE_JAL, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0);
      step();
      idle_inputs();
      check("jal_valid", 32'(redirect_valid_o), 32'd1);
      check("jal_pc",    redirect_pc_o,         32'h4);
      step();
      step();
      step();
      check_quiet("jal_idle");

`ifdef BRCTRL_PERF_EN
      // Branches: BEQ, BNE, BLT, 010, BLTU. Taken: BEQ, JALR, BLT, JAL.
      check("perf_branch_cnt", branch_cnt_o, 32'd5);
      check("perf_taken_cnt",  taken_cnt_o,  32'd4);
`endif

      // Reset asserted mid-FLUSH clears outputs without a clock edge.
      drive(OPCODE_BRANCH, F3_BEQ, 1'b1, 1'b0, 32'h100, 32'h20, 32'h0);
      step();
      idle_inputs();
      step();
      check("rst_pre_flush", 32'(flush_o), 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      check_quiet("rst_async");
`ifdef BRCTRL_PERF_EN
      check("rst_branch_cnt", branch_cnt_o, 32'd0);
      check("rst_taken_cnt",  taken_cnt_o,  32'd0);
`endif
      step();
      rst_ni = 1'b1;
      step();
      check_quiet("rst_release");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_branch_redirect_ctrl
